// File: rtl/uart_rx_frame_fifo_pkg.sv
// Shared frame layout for the UART receive path: field positions, framing bit values
// and the start/stop check used by uart_rx_frame_fifo.
package uart_pkg;
    localparam int   FRAME_W   = 10;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_LSB  = 1;
    localparam int   DATA_MSB  = 8;
    localparam int   DATA_W    = DATA_MSB - DATA_LSB + 1;

    typedef logic [DATA_W-1:0]  byte_t;
    typedef logic [FRAME_W-1:0] frame_t;

    function automatic logic frame_ok(input frame_t f);
        return (f[0] == START_BIT) && (f[FRAME_W-1] == STOP_BIT);
    endfunction
endpackage

// File: rtl/uart_rx_frame_fifo_if.sv
// Host read port of uart_rx_frame_fifo: show-ahead valid/ready byte stream plus fill level.
// master = FIFO side, slave = host side.
interface uart_rx_frame_fifo_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;
    localparam int AW = $clog2(DEPTH);

    byte_t       rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [AW:0] level;

    modport master (output rd_data, output rd_valid, output level, input rd_ready);
    modport slave  (input rd_data, input rd_valid, input level, output rd_ready);
endinterface

// File: rtl/uart_rx_frame_fifo_sync_fifo.sv
// Single-clock FIFO with AW+1 bit wrapping pointers and show-ahead read data.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
        level   = wptr_q - rptr_q;
        // Zero while empty so the read port shows a clean value out of reset.
        rdata   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/uart_rx_frame_fifo.sv
// UART receive back end: resynchronises the frame strobe, checks framing, buffers bytes, raises irq.
// Optional macro UART_RX_STATS_EN adds saturating frm_cnt/ovf_cnt error counters.
module uart_rx_frame_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int IRQ_THRESH = 1
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   irq_rx_in,
    input  frame_t                 frame_in,
    uart_rx_frame_fifo_if.master   host,
    output logic                   frm_err,
    output logic                   ovf,
    output logic                   err_sticky,
    input  logic                   clr_err,
    output logic                   irq
`ifdef UART_RX_STATS_EN
    ,
    output logic [7:0]             frm_cnt,
    output logic [7:0]             ovf_cnt
`endif
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] THRESH_L = (AW+1)'(IRQ_THRESH);

    logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [1:0]  warm_q, warm_d;
    logic        armed_q, armed_d;
    logic        frm_err_q, frm_err_d, ovf_q, ovf_d;
    logic        err_sticky_q, err_sticky_d;
    logic        push_evt, ok, pop, wr, bad_evt, ovf_evt;
    logic        fifo_full, fifo_empty;
    byte_t       fifo_rdata;
    logic [AW:0] fifo_level;

    uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk   (clk),
        .rst   (RST),
        .push  (wr),
        .wdata (frame_in[DATA_MSB:DATA_LSB]),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // armed only after the synchroniser has shown a low strobe following reset,
    // so a strobe already high when reset is released is never taken as a new frame.
    always_comb begin
        s1_d     = irq_rx_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        warm_d   = {warm_q[0], 1'b1};
        armed_d  = armed_q | (warm_q[1] & ~s2_q);
        push_evt = s2_q & ~s3_q & armed_q;
        ok       = frame_ok(frame_in);
        pop      = ~fifo_empty & host.rd_ready;
        bad_evt  = push_evt & ~ok;
        wr       = push_evt & ok & (~fifo_full | pop);
        ovf_evt  = push_evt & ok & fifo_full & ~pop;
        frm_err_d = bad_evt;
        ovf_d     = ovf_evt;
        err_sticky_d = (bad_evt | ovf_evt) ? 1'b1 : (clr_err ? 1'b0 : err_sticky_q);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            warm_q       <= '0;
            armed_q      <= 1'b0;
            frm_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            warm_q       <= warm_d;
            armed_q      <= armed_d;
            frm_err_q    <= frm_err_d;
            ovf_q        <= ovf_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign host.rd_data  = fifo_rdata;
    assign host.rd_valid = ~fifo_empty;
    assign host.level    = fifo_level;
    assign frm_err       = frm_err_q;
    assign ovf           = ovf_q;
    assign err_sticky    = err_sticky_q;
    assign irq           = (fifo_level >= THRESH_L) | err_sticky_q;

`ifdef UART_RX_STATS_EN
    logic [7:0] frm_cnt_q, frm_cnt_d, ovf_cnt_q, ovf_cnt_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // A clear in the same cycle as an event restarts the count at 1.
    always_comb begin
        frm_cnt_d = clr_err ? {7'd0, bad_evt} : (bad_evt ? sat_inc(frm_cnt_q) : frm_cnt_q);
        ovf_cnt_d = clr_err ? {7'd0, ovf_evt} : (ovf_evt ? sat_inc(ovf_cnt_q) : ovf_cnt_q);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            frm_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign frm_cnt = frm_cnt_q;
    assign ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_frame_fifo.sv
// Scoreboard bench for uart_rx_frame_fifo: stimulus queues expected bytes, a negedge monitor checks pops.
// A second instance with IRQ_THRESH=4 shares the frame inputs for the threshold case.
module tb_uart_rx_frame_fifo;
    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       irq_rx_in = 1'b0;
    logic       clr_err = 1'b0;
    logic [9:0] frame_in = '0;
    logic       frm_err, ovf, err_sticky, irq;
    logic       frm_err2, ovf2, err_sticky2, irq2;
`ifdef UART_RX_STATS_EN
    logic [7:0] frm_cnt, ovf_cnt, frm_cnt2, ovf_cnt2;
`endif

    uart_rx_frame_fifo_if #(.DEPTH(16)) hif ();
    uart_rx_frame_fifo_if #(.DEPTH(16)) hif2 ();

    uart_rx_frame_fifo #(.DEPTH(16), .IRQ_THRESH(1)) dut (
        .clk(clk), .RST(RST), .irq_rx_in(irq_rx_in), .frame_in(frame_in), .host(hif),
        .frm_err(frm_err), .ovf(ovf), .err_sticky(err_sticky), .clr_err(clr_err), .irq(irq)
`ifdef UART_RX_STATS_EN
        , .frm_cnt(frm_cnt), .ovf_cnt(ovf_cnt)
`endif
    );

    uart_rx_frame_fifo #(.DEPTH(16), .IRQ_THRESH(4)) u_thr (
        .clk(clk), .RST(RST), .irq_rx_in(irq_rx_in), .frame_in(frame_in), .host(hif2),
        .frm_err(frm_err2), .ovf(ovf2), .err_sticky(err_sticky2), .clr_err(clr_err), .irq(irq2)
`ifdef UART_RX_STATS_EN
        , .frm_cnt(frm_cnt2), .ovf_cnt(ovf_cnt2)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    int         n_frm = 0;
    int         n_ovf = 0;
    logic [7:0] sb_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: count error pulses and check every accepted pop against the scoreboard.
    always @(negedge clk) begin
        if (frm_err) n_frm++;
        if (ovf) n_ovf++;
        if (!RST && hif.rd_valid && hif.rd_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected no data", hif.rd_data);
            end else begin
                chk("rd_data", {24'd0, hif.rd_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    function automatic logic [9:0] mk(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    // side: 0 none, 1 rd_ready during the push cycle, 2 clr_err during the push cycle
    task automatic send_frame(input logic [9:0] f, input bit store, input int side);
        @(posedge clk); #1;
        frame_in  = f;
        irq_rx_in = 1'b1;
        if (store) sb_q.push_back(f[8:1]);
        @(posedge clk);
        @(posedge clk); #1;
        if (side == 1) hif.rd_ready = 1'b1;
        if (side == 2) clr_err = 1'b1;
        @(posedge clk); #1;
        hif.rd_ready = 1'b0;
        clr_err      = 1'b0;
        @(posedge clk); #1;
        irq_rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        hif.rd_ready = 1'b1;
        while (hif.rd_valid && k < 64) begin
            @(posedge clk); #1;
            k++;
        end
        hif.rd_ready = 1'b0;
        chk("drain_timeout", {31'd0, k < 64}, 32'd1);
        chk("sb_empty", sb_q.size(), 32'd0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 RST = 1'b1;
        sb_q.delete();
        @(posedge clk); #1 RST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_valid"}, {31'd0, hif.rd_valid}, 32'd0);
        chk({tag, "_rd_data"}, {24'd0, hif.rd_data}, 32'd0);
        chk({tag, "_level"}, {27'd0, hif.level}, 32'd0);
        chk({tag, "_frm_err"}, {31'd0, frm_err}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
        chk({tag, "_err_sticky"}, {31'd0, err_sticky}, 32'd0);
        chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, no;
        hif.rd_ready  = 1'b0;
        hif2.rd_ready = 1'b0;
        #12;
        chk_all_zero("reset");
        @(posedge clk); #1 RST = 1'b0;
        repeat (3) @(posedge clk);

        // 1: good frame B5, rd_valid after the third edge
        @(posedge clk); #1;
        frame_in  = 10'b1_10110101_0;
        irq_rx_in = 1'b1;
        sb_q.push_back(8'hB5);
        @(posedge clk);
        @(posedge clk); #1;
        chk("t1_valid_early", {31'd0, hif.rd_valid}, 32'd0);
        @(posedge clk); #1;
        chk("t1_valid", {31'd0, hif.rd_valid}, 32'd1);
        chk("t1_data", {24'd0, hif.rd_data}, 32'hB5);
        chk("t1_level", {27'd0, hif.level}, 32'd1);
        chk("t1_irq", {31'd0, irq}, 32'd1);
        @(posedge clk); #1 irq_rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        drain();
        chk("t1_irq_drop", {31'd0, irq}, 32'd0);

        // 2: bad stop bit, then bad start bit with clr_err in the same cycle
        nf = n_frm;
        send_frame(10'b0_01010101_0, 1'b0, 0);
        chk("t2_frm_pulses", n_frm, nf + 1);
        chk("t2_level", {27'd0, hif.level}, 32'd0);
        chk("t2_sticky", {31'd0, err_sticky}, 32'd1);
        chk("t2_irq_err", {31'd0, irq}, 32'd1);
        pulse_clr();
        chk("t2_sticky_clr", {31'd0, err_sticky}, 32'd0);
        chk("t2_irq_clr", {31'd0, irq}, 32'd0);
        send_frame(10'b1_00001111_1, 1'b0, 2);
        chk("t2_set_wins", {31'd0, err_sticky}, 32'd1);
        chk("t2_frm_pulses2", n_frm, nf + 2);
        pulse_clr();

        // 3: fill to 16, the 17th overflows
        for (int i = 0; i < 16; i++) send_frame(mk(8'h10 + 8'(i)), 1'b1, 0);
        chk("t3_level_full", {27'd0, hif.level}, 32'd16);
        chk("t3_sticky_clean", {31'd0, err_sticky}, 32'd0);
        no = n_ovf;
        send_frame(mk(8'hEE), 1'b0, 0);
        chk("t3_ovf_pulse", n_ovf, no + 1);
        chk("t3_level_after", {27'd0, hif.level}, 32'd16);
        chk("t3_sticky", {31'd0, err_sticky}, 32'd1);
        pulse_clr();

        // 4: push at full with a same-cycle pop
        no = n_ovf;
        send_frame(mk(8'hA7), 1'b1, 1);
        chk("t4_no_ovf", n_ovf, no);
        chk("t4_level", {27'd0, hif.level}, 32'd16);
        chk("t4_head", {24'd0, hif.rd_data}, 32'h11);
        chk("t4_sticky", {31'd0, err_sticky}, 32'd0);
        drain();
        chk("t34_level_empty", {27'd0, hif.level}, 32'd0);

        // 5: threshold 4 on the second instance
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(mk(8'h40 + 8'(i)), 1'b1, 0);
        chk("t5_level3", {27'd0, hif2.level}, 32'd3);
        chk("t5_irq_low", {31'd0, irq2}, 32'd0);
        send_frame(mk(8'h43), 1'b1, 0);
        chk("t5_level4", {27'd0, hif2.level}, 32'd4);
        chk("t5_irq_high", {31'd0, irq2}, 32'd1);
        @(posedge clk); #1 hif2.rd_ready = 1'b1;
        @(posedge clk); #1 hif2.rd_ready = 1'b0;
        chk("t5_level_pop", {27'd0, hif2.level}, 32'd3);
        chk("t5_irq_drop", {31'd0, irq2}, 32'd0);

        // 6: reset with 5 entries while a strobe is high
        send_frame(mk(8'h44), 1'b1, 0);
        chk("t6_level5", {27'd0, hif.level}, 32'd5);
        @(posedge clk); #1;
        frame_in  = mk(8'h66);
        irq_rx_in = 1'b1;
        @(posedge clk); #1 RST = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;
        repeat (5) @(posedge clk);
        #1 irq_rx_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_no_capture", {27'd0, hif.level}, 32'd0);
        chk("t6_valid", {31'd0, hif.rd_valid}, 32'd0);
        send_frame(mk(8'h3C), 1'b1, 0);
        chk("t6_after_level", {27'd0, hif.level}, 32'd1);
        drain();

`ifdef UART_RX_STATS_EN
        pulse_clr();
        chk("st_frm_clr", {24'd0, frm_cnt}, 32'd0);
        repeat (300) send_frame(10'b0_00000000_0, 1'b0, 0);
        chk("st_frm_sat", {24'd0, frm_cnt}, 32'd255);
        chk("st_ovf_cnt", {24'd0, ovf_cnt}, 32'd0);
        pulse_clr();
        chk("st_frm_clr2", {24'd0, frm_cnt}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
